// File: rtl/instr_decode_pkg.sv
// rtl/instr_decode_pkg.sv - shared RV32I opcode, funct and ALU constants for the decoder
package instr_decode_pkg;

    // Major opcodes
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_I_TYPE = 7'b0010011;
    localparam logic [6:0] OPCODE_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

    // funct3 values for OP / OP-IMM
    localparam logic [2:0] FUNCT3_ADD  = 3'b000;
    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SLT  = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU = 3'b011;
    localparam logic [2:0] FUNCT3_XOR  = 3'b100;
    localparam logic [2:0] FUNCT3_SR   = 3'b101;
    localparam logic [2:0] FUNCT3_OR   = 3'b110;
    localparam logic [2:0] FUNCT3_AND  = 3'b111;

    // funct7 variants; bit 5 selects SUB / SRA
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
    localparam int         FUNCT7_ALT_BIT = 5;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_ADDI = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_XOR  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    // Control bundle bit positions
    localparam int CTRL_REG_WRITE   = 0;
    localparam int CTRL_ALU_SRC_IMM = 1;
    localparam int CTRL_MEM_READ    = 2;
    localparam int CTRL_MEM_WRITE   = 3;
    localparam int CTRL_MEM_TO_REG  = 4;
    localparam int CTRL_BRANCH      = 5;
    localparam int CTRL_JUMP        = 6;
    localparam int CTRL_JALR        = 7;

    // Immediate format selector handed to the immediate generator
    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_SHAMT,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // funct3 -> ALU op; alt picks SUB for 000 and SRA for 101
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            FUNCT3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            FUNCT3_SLL:  op = ALU_SLL;
            FUNCT3_SLT:  op = ALU_SLT;
            FUNCT3_SLTU: op = ALU_SLTU;
            FUNCT3_XOR:  op = ALU_XOR;
            FUNCT3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            FUNCT3_OR:   op = ALU_OR;
            FUNCT3_AND:  op = ALU_AND;
            default:     op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instr_decode_if.sv
// rtl/instr_decode_if.sv - instruction in / decoded fields out bundle
interface instr_decode_if;
    logic [31:0] instruction_encoding;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic [7:0]  control_unit_signal;
    logic        flush_cs;

    // Fetch side: supplies the word, observes the decode
    modport master (
        output instruction_encoding,
        input  opcode, funct3, funct7, rs1, rs2, rd, imm, alu_op,
               control_unit_signal, flush_cs
    );

    // Decoder side
    modport slave (
        input  instruction_encoding,
        output opcode, funct3, funct7, rs1, rs2, rd, imm, alu_op,
               control_unit_signal, flush_cs
    );
endinterface

// File: rtl/instr_decode_imm_gen.sv
// rtl/instr_decode_imm_gen.sv - combinational format-select immediate generator
module instr_decode_imm_gen
    import instr_decode_pkg::*;
(
    input  logic [31:7] instr_i,
    input  imm_fmt_e    fmt_i,
    output logic [31:0] imm_o
);

    // Assemble the immediate for the selected format; unknown formats yield 0
    always_comb begin
        imm_o = 32'h0;
        case (fmt_i)
            IMM_I:     imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_SHAMT: imm_o = {27'h0, instr_i[24:20]};
            IMM_S:     imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:     imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:     imm_o = {instr_i[31:12], 12'h0};
            IMM_J:     imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                instr_i[20], instr_i[30:21], 1'b0};
            default:   imm_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - registered RV32I decoder between fetch and execute
module instr_decode
    import instr_decode_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    instr_decode_if.slave dec
);

    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;

    assign instr = dec.instruction_encoding;
    assign op    = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];

    imm_fmt_e    imm_fmt;
    logic [31:0] imm_d;
    logic [3:0]  alu_op_d;
    logic [7:0]  ctrl_d;
    logic        flush_d;
    logic        zero_rs1;
    logic        zero_rs2;
    logic        zero_rd;
    logic [4:0]  rs1_d;
    logic [4:0]  rs2_d;
    logic [4:0]  rd_d;

    logic [6:0]  opcode_q;
    logic [2:0]  funct3_q;
    logic [6:0]  funct7_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [4:0]  rd_q;
    logic [31:0] imm_q;
    logic [3:0]  alu_op_q;
    logic [7:0]  ctrl_q;
    logic        flush_q;

    instr_decode_imm_gen u_imm_gen (
        .instr_i (instr[31:7]),
        .fmt_i   (imm_fmt),
        .imm_o   (imm_d)
    );

    // Per-opcode control decode; unknown opcodes fall through as a no-op
    always_comb begin
        ctrl_d   = 8'h00;
        alu_op_d = ALU_ADD;
        flush_d  = 1'b0;
        imm_fmt  = IMM_NONE;
        zero_rs1 = 1'b0;
        zero_rs2 = 1'b0;
        zero_rd  = 1'b0;
        case (op)
            OPCODE_LUI, OPCODE_AUIPC: begin
                imm_fmt  = IMM_U;
                alu_op_d = ALU_ADDI;
                zero_rs1 = 1'b1;
                zero_rs2 = 1'b1;
                ctrl_d[CTRL_REG_WRITE]   = 1'b1;
                ctrl_d[CTRL_ALU_SRC_IMM] = 1'b1;
            end
            OPCODE_I_TYPE: begin
                imm_fmt  = (f3 == FUNCT3_SLL || f3 == FUNCT3_SR) ? IMM_SHAMT : IMM_I;
                // Only shifts look at funct7; ADDI with a negative imm must not become SUB
                alu_op_d = alu_from_funct3(f3, (f3 == FUNCT3_SR) && f7[FUNCT7_ALT_BIT]);
                zero_rs2 = 1'b1;
                ctrl_d[CTRL_REG_WRITE]   = 1'b1;
                ctrl_d[CTRL_ALU_SRC_IMM] = 1'b1;
            end
            OPCODE_R_TYPE: begin
                alu_op_d = alu_from_funct3(f3, f7[FUNCT7_ALT_BIT]);
                ctrl_d[CTRL_REG_WRITE] = 1'b1;
            end
            OPCODE_LOAD: begin
                imm_fmt  = IMM_I;
                zero_rs2 = 1'b1;
                ctrl_d[CTRL_REG_WRITE]   = 1'b1;
                ctrl_d[CTRL_ALU_SRC_IMM] = 1'b1;
                ctrl_d[CTRL_MEM_READ]    = 1'b1;
                ctrl_d[CTRL_MEM_TO_REG]  = 1'b1;
            end
            OPCODE_STORE: begin
                imm_fmt = IMM_S;
                zero_rd = 1'b1;
                ctrl_d[CTRL_ALU_SRC_IMM] = 1'b1;
                ctrl_d[CTRL_MEM_WRITE]   = 1'b1;
            end
            OPCODE_BRANCH: begin
                imm_fmt  = IMM_B;
                alu_op_d = ALU_SUB;
                zero_rd  = 1'b1;
                ctrl_d[CTRL_BRANCH] = 1'b1;
            end
            OPCODE_JAL: begin
                imm_fmt  = IMM_J;
                zero_rs1 = 1'b1;
                zero_rs2 = 1'b1;
                flush_d  = 1'b1;
                ctrl_d[CTRL_REG_WRITE] = 1'b1;
                ctrl_d[CTRL_JUMP]      = 1'b1;
            end
            OPCODE_JALR: begin
                imm_fmt  = IMM_I;
                zero_rs2 = 1'b1;
                flush_d  = 1'b1;
                ctrl_d[CTRL_REG_WRITE]   = 1'b1;
                ctrl_d[CTRL_ALU_SRC_IMM] = 1'b1;
                ctrl_d[CTRL_JUMP]        = 1'b1;
                ctrl_d[CTRL_JALR]        = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign rs1_d = zero_rs1 ? 5'd0 : instr[19:15];
    assign rs2_d = zero_rs2 ? 5'd0 : instr[24:20];
    assign rd_d  = zero_rd  ? 5'd0 : instr[11:7];

    // Output register; reset yields an all-zero "no operation" decode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode_q <= 7'd0;
            funct3_q <= 3'd0;
            funct7_q <= 7'd0;
            rs1_q    <= 5'd0;
            rs2_q    <= 5'd0;
            rd_q     <= 5'd0;
            imm_q    <= 32'd0;
            alu_op_q <= 4'd0;
            ctrl_q   <= 8'd0;
            flush_q  <= 1'b0;
        end else begin
            opcode_q <= op;
            funct3_q <= f3;
            funct7_q <= f7;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            imm_q    <= imm_d;
            alu_op_q <= alu_op_d;
            ctrl_q   <= ctrl_d;
            flush_q  <= flush_d;
        end
    end

    assign dec.opcode              = opcode_q;
    assign dec.funct3              = funct3_q;
    assign dec.funct7              = funct7_q;
    assign dec.rs1                 = rs1_q;
    assign dec.rs2                 = rs2_q;
    assign dec.rd                  = rd_q;
    assign dec.imm                 = imm_q;
    assign dec.alu_op              = alu_op_q;
    assign dec.control_unit_signal = ctrl_q;
    assign dec.flush_cs            = flush_q;

endmodule

// File: tb/tb_instr_decode.sv
// tb/tb_instr_decode.sv - scoreboard bench for the registered instruction decoder
module tb_instr_decode;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic [7:0]  ctrl;
        logic        flush;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    exp_t sb[$];

    instr_decode_if bus ();

    instr_decode dut (
        .clk   (clk),
        .reset (reset),
        .dec   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    function automatic exp_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] imm, input logic [3:0] alu, input logic [7:0] ctrl,
                                input logic fl);
        exp_t e;
        e.opcode = op; e.funct3 = f3; e.funct7 = f7;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.imm = imm; e.alu_op = alu; e.ctrl = ctrl; e.flush = fl;
        return e;
    endfunction

    // Reference ALU table for OP / OP-IMM keyed by funct3 and instr[30]
    function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic b30, input logic is_r);
        logic [3:0] a;
        case (f3)
            3'd0: a = (is_r && b30) ? 4'd1 : 4'd0;
            3'd1: a = 4'd5;
            3'd2: a = 4'd8;
            3'd3: a = 4'd9;
            3'd4: a = 4'd2;
            3'd5: a = b30 ? 4'd7 : 4'd6;
            3'd6: a = 4'd3;
            default: a = 4'd4;
        endcase
        return a;
    endfunction

    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        logic [31:0] imm_i;
        imm_i = {{20{w[31]}}, w[31:20]};
        e = mk(w[6:0], w[14:12], w[31:25], w[19:15], w[24:20], w[11:7], 32'h0, 4'd0, 8'h00, 1'b0);
        case (w[6:0])
            7'h37, 7'h17: begin
                e.rs1 = 0; e.rs2 = 0; e.imm = {w[31:12], 12'h000}; e.ctrl = 8'h03;
            end
            7'h13: begin
                e.rs2 = 0; e.ctrl = 8'h03;
                e.imm = (w[14:12] == 3'd1 || w[14:12] == 3'd5) ? {27'h0, w[24:20]} : imm_i;
                e.alu_op = ref_alu(w[14:12], w[30], 1'b0);
            end
            7'h33: begin
                e.ctrl = 8'h01; e.alu_op = ref_alu(w[14:12], w[30], 1'b1);
            end
            7'h03: begin
                e.rs2 = 0; e.imm = imm_i; e.ctrl = 8'h17;
            end
            7'h23: begin
                e.rd = 0; e.imm = {{20{w[31]}}, w[31:25], w[11:7]}; e.ctrl = 8'h0A;
            end
            7'h63: begin
                e.rd = 0; e.alu_op = 4'd1; e.ctrl = 8'h20;
                e.imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            end
            7'h6f: begin
                e.rs1 = 0; e.rs2 = 0; e.ctrl = 8'h41; e.flush = 1'b1;
                e.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
            end
            7'h67: begin
                e.rs2 = 0; e.imm = imm_i; e.ctrl = 8'hC3; e.flush = 1'b1;
            end
            default: begin
            end
        endcase
        return e;
    endfunction

    task automatic compare(input exp_t e);
        chk("opcode", 32'(bus.opcode), 32'(e.opcode));
        chk("funct3", 32'(bus.funct3), 32'(e.funct3));
        chk("funct7", 32'(bus.funct7), 32'(e.funct7));
        chk("rs1",    32'(bus.rs1),    32'(e.rs1));
        chk("rs2",    32'(bus.rs2),    32'(e.rs2));
        chk("rd",     32'(bus.rd),     32'(e.rd));
        chk("imm",    bus.imm,         e.imm);
        chk("alu_op", 32'(bus.alu_op), 32'(e.alu_op));
        chk("ctrl",   32'(bus.control_unit_signal), 32'(e.ctrl));
        chk("flush",  32'(bus.flush_cs), 32'(e.flush));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_opcode"}, 32'(bus.opcode), 32'h0);
        chk({tag, "_fields"}, 32'({bus.funct3, bus.funct7, bus.rs1, bus.rs2, bus.rd}), 32'h0);
        chk({tag, "_imm"},    bus.imm, 32'h0);
        chk({tag, "_alu"},    32'(bus.alu_op), 32'h0);
        chk({tag, "_ctrl"},   32'(bus.control_unit_signal), 32'h0);
        chk({tag, "_flush"},  32'(bus.flush_cs), 32'h0);
    endtask

    // Compare the previous word's decode, then drive the next word
    task automatic send(input logic [31:0] w, input exp_t e);
        @(negedge clk);
        if (sb.size() > 0) compare(sb.pop_front());
        bus.instruction_encoding = w;
        sb.push_back(e);
    endtask

    task automatic drain();
        @(negedge clk);
        if (sb.size() > 0) compare(sb.pop_front());
    endtask

    localparam logic [6:0] OPS [11] = '{7'h37, 7'h17, 7'h13, 7'h33, 7'h03, 7'h23,
                                        7'h63, 7'h6f, 7'h67, 7'h7f, 7'h0f};

    initial begin
        logic [31:0] w;
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        bus.instruction_encoding = 32'h0;
        #12;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        send(32'h000600b7, mk(7'h37, 3'd0, 7'h00, 5'd0,  5'd0, 5'd1,  32'h00060000, 4'd0, 8'h03, 1'b0));
        send(32'h01028313, mk(7'h13, 3'd0, 7'h00, 5'd5,  5'd0, 5'd6,  32'h00000010, 4'd0, 8'h03, 1'b0));
        send(32'h01f59293, mk(7'h13, 3'd1, 7'h00, 5'd11, 5'd0, 5'd5,  32'h0000001F, 4'd5, 8'h03, 1'b0));
        send(32'h001bda93, mk(7'h13, 3'd5, 7'h00, 5'd23, 5'd0, 5'd21, 32'h00000001, 4'd6, 8'h03, 1'b0));
        send(32'h0080006f, mk(7'h6f, 3'd0, 7'h00, 5'd0,  5'd0, 5'd0,  32'h00000008, 4'd0, 8'h41, 1'b1));
        send(32'hfe0008e3, mk(7'h63, 3'd0, 7'h7f, 5'd0,  5'd0, 5'd0,  32'hFFFFFFF0, 4'd1, 8'h20, 1'b0));
        send(32'h4010d093, mk(7'h13, 3'd5, 7'h20, 5'd1,  5'd0, 5'd1,  32'h00000001, 4'd7, 8'h03, 1'b0));
        send(32'h40208033, mk(7'h33, 3'd0, 7'h20, 5'd1,  5'd2, 5'd0,  32'h00000000, 4'd1, 8'h01, 1'b0));
        send(32'hffffffff, mk(7'h7f, 3'd7, 7'h7f, 5'd31, 5'd31, 5'd31, 32'h00000000, 4'd0, 8'h00, 1'b0));

        for (int i = 0; i < 60; i++) begin
            w = $urandom;
            w[6:0] = OPS[$urandom_range(0, 10)];
            send(w, model(w));
        end
        send(32'h00c58067, model(32'h00c58067));
        drain();

        // Asynchronous reset mid-stream, away from any clock edge
        #2;
        reset = 1'b1;
        #1;
        check_zero("mid_rst");
        sb.delete();
        @(posedge clk);
        #1;
        check_zero("rst_hold");
        @(negedge clk);
        reset = 1'b0;
        send(32'h000600b7, mk(7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h00060000, 4'd0, 8'h03, 1'b0));
        send(32'h01028313, model(32'h01028313));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_decode.md
# instr_decode

Registered RV32I instruction decoder for the decode stage of the pipeline. It splits a 32-bit instruction into its fields and builds a sign-extended immediate. It also produces a 4-bit ALU operation code, an 8-bit control bundle and a control-flow flush flag. It sits between fetch and execute; all outputs are registered once.

## Interface
- No parameters. Opcode, funct3 and ALU codes come from the shared constants in `define.vh`.
- `clk` input 1: sole clock; all outputs update on the rising edge.
- `reset` input 1: asynchronous, active-high; clears every output register.
- `instruction_encoding` input 32: instruction word.
- `opcode` output 7: instr[6:0].
- `funct3` output 3: instr[14:12].
- `funct7` output 7: instr[31:25].
- `rs1` output 5: instr[19:15]; forced to 0 for LUI, JAL and AUIPC.
- `rs2` output 5: instr[24:20]; forced to 0 for U, J and I formats.
- `rd` output 5: instr[11:7]; forced to 0 for S and B formats.
- `imm` output 32: decoded immediate.
- `alu_op` output 4: ALU operation code.
- `control_unit_signal` output 8: [0] reg_write, [1] alu_src_imm, [2] mem_read, [3] mem_write, [4] mem_to_reg, [5] branch, [6] jump, [7] jalr.
- `flush_cs` output 1: unconditional control transfer (JAL/JALR); the front end flushes younger instructions.

## Operation
Immediate formats; all are sign-extended from instr[31] unless noted:
- I: instr[31:20].
- Shift-immediate (funct3 001/101, opcode I_TYPE): zero-extended instr[24:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.

alu_op codes (define.vh): ADD/ADDI=0, SUB=1, XOR=2, OR=3, AND=4, SLL/SLLI=5, SRL/SRLI=6, SRA/SRAI=7, SLT=8, SLTU=9.

Per-opcode decoding:
- OPCODE_LUI 0110111: ALU_ADDI with rs1=0; ctrl 0x03.
- AUIPC 0010111: ALU_ADDI; ctrl 0x03.
- OPCODE_I_TYPE 0010011: alu_op from funct3, with SRAI when funct3=101 and funct7[5]=1; ctrl 0x03.
- R 0110011: alu_op from funct3 and funct7[5], with SUB when funct3=000 and funct7[5]=1; ctrl 0x01.
- LOAD 0000011: ADD; ctrl 0x17.
- STORE 0100011: ADD; ctrl 0x0A.
- BRANCH 1100011: SUB; ctrl 0x20.
- JAL 1101111: ADD; ctrl 0x41; flush_cs=1.
- JALR 1100111: ADD; ctrl 0xC3; flush_cs=1.
- Any other opcode: ctrl=0x00, alu_op=0, imm=0, flush_cs=0. Field outputs still pass through.

## Timing
- The combinational decode is captured on the rising edge of `clk`. Latency is 1 cycle: outputs reflect the instruction present at the previous rising edge.
- `reset` asserted at any time clears all outputs to 0 immediately, with no clock needed. The cleared state decodes as "no operation" (ctrl 0, flush 0).
- The first edge after `reset` deasserts captures normally.
- No handshake; a new instruction is accepted every cycle.

## Structure
- Shared package / `define.vh` holds OPCODE_*, FUNCT3_*, FUNCT7 variants, ALU_* codes and control-bit index names.
- Natural sub-module: `imm_gen`, a combinational format-select immediate generator.
- The rest is one case on opcode plus an output register block.

## Test plan
- Reset asserted mid-stream -> all outputs 0 asynchronously. After release, input 0x000600b7 and one edge -> normal decode resumes.
- 0x000600b7 (lui x1,0x60) -> opcode 0110111, rd=1, imm=0x00060000, alu_op=ALU_ADDI, ctrl=0x03, flush_cs=0.
- 0x01028313 (addi x6,x5,16) -> funct3 000, rs1=5, rd=6, imm=0x10, ALU_ADDI, ctrl=0x03.
- 0x01f59293 (slli x5,x11,31) -> funct3 001, funct7 0, rs1=11, rd=5, imm=0x1F, ALU_SLLI, ctrl=0x03.
- 0x001bda93 (srli x21,x23,1) -> funct3 101, funct7 0, rs1=23, rd=21, imm=1, ALU_SRLI, ctrl=0x03.
- 0x0080006f (jal x0,8) -> imm=8, ctrl=0x41, flush_cs=1. 0xfe0008e3 (beq x0,x0,-16) -> imm=0xFFFFFFF0, ctrl=0x20, flush_cs=0.
